// File: rtl/sram_responder_if.sv
// Instruction and data SRAM-like port bundle between the core (master) and
// the memory responder (slave).
interface sram_responder_if;
  logic        inst_sram_en;
  logic [3:0]  inst_sram_wen;
  logic [31:0] inst_sram_addr;
  logic [31:0] inst_sram_wdata;
  logic [31:0] inst_sram_rdata;

  logic        data_sram_en;
  logic [3:0]  data_sram_wen;
  logic [31:0] data_sram_addr;
  logic [31:0] data_sram_wdata;
  logic [31:0] data_sram_rdata;

  modport master (
    output inst_sram_en, inst_sram_wen, inst_sram_addr, inst_sram_wdata,
    output data_sram_en, data_sram_wen, data_sram_addr, data_sram_wdata,
    input  inst_sram_rdata, data_sram_rdata
  );

  modport slave (
    input  inst_sram_en, inst_sram_wen, inst_sram_addr, inst_sram_wdata,
    input  data_sram_en, data_sram_wen, data_sram_addr, data_sram_wdata,
    output inst_sram_rdata, data_sram_rdata
  );
endinterface

// File: rtl/sram_responder.sv
// Shared-array responder for the core's inst/data ports with fixed 1-cycle reads
// and an MMIO window (TIMER/LED/NUM). Define SRAM_TIMER_EN to build the timer.
module sram_responder #(
  parameter int          AW        = 16,
  parameter logic [15:0] MMIO_BASE = 16'hBFAF
) (
  input  logic              clk,
  input  logic              rst,
  sram_responder_if.slave   bus,
  output logic [15:0]       led,
  output logic [31:0]       num
);

  localparam logic [15:0] OFF_TIMER = 16'hE000;
  localparam logic [15:0] OFF_LED   = 16'hF000;
  localparam logic [15:0] OFF_NUM   = 16'hF010;

  function automatic logic [31:0] merge(input logic [31:0] old_w,
                                        input logic [31:0] new_w,
                                        input logic [3:0]  be);
    merge = old_w;
    for (int i = 0; i < 4; i++)
      if (be[i]) merge[8*i +: 8] = new_w[8*i +: 8];
  endfunction

  logic [31:0] mem_q [0:(2**AW)-1];

  logic [AW-1:0] i_idx, d_idx;
  logic [15:0]   d_off;
  logic          d_mmio, arr_wr, mmio_wr;
  logic [31:0]   timer_val, mmio_rdata;

  logic [31:0] inst_rdata_q, inst_rdata_d;
  logic [31:0] data_rdata_q, data_rdata_d;
  logic [15:0] led_q, led_d;
  logic [31:0] num_q, num_d;

  // Ports that the responder never looks at; kept visible to avoid dangling inputs.
  logic unused_bits;
  assign unused_bits = ^{bus.inst_sram_wen, bus.inst_sram_wdata,
                         bus.inst_sram_addr[31:AW+2], bus.inst_sram_addr[1:0],
                         bus.data_sram_addr[1:0]};

  always_comb begin
    i_idx   = bus.inst_sram_addr[AW+1:2];
    d_idx   = bus.data_sram_addr[AW+1:2];
    d_off   = {bus.data_sram_addr[15:2], 2'b00};
    d_mmio  = (bus.data_sram_addr[31:16] == MMIO_BASE);
    arr_wr  = bus.data_sram_en && !d_mmio && (bus.data_sram_wen != 4'b0000);
    mmio_wr = bus.data_sram_en &&  d_mmio && (bus.data_sram_wen != 4'b0000);
  end

`ifdef SRAM_TIMER_EN
  logic [31:0] timer_q, timer_d;

  // A software write replaces the increment for that edge.
  always_comb begin
    timer_d = timer_q + 32'd1;
    if (mmio_wr && d_off == OFF_TIMER)
      timer_d = merge(timer_q, bus.data_sram_wdata, bus.data_sram_wen);
  end

  always_ff @(posedge clk) begin
    if (rst) timer_q <= '0;
    else     timer_q <= timer_d;
  end

  assign timer_val = timer_q;
`else
  assign timer_val = '0;
`endif

  always_comb begin
    mmio_rdata = '0;
    case (d_off)
      OFF_TIMER: mmio_rdata = timer_val;
      OFF_LED:   mmio_rdata = {16'h0000, led_q};
      OFF_NUM:   mmio_rdata = num_q;
      default:   mmio_rdata = '0;
    endcase
  end

  // Reads sample the array/registers before this edge's updates (read-first).
  always_comb begin
    inst_rdata_d = inst_rdata_q;
    data_rdata_d = data_rdata_q;
    led_d        = led_q;
    num_d        = num_q;
    if (bus.inst_sram_en) inst_rdata_d = mem_q[i_idx];
    if (bus.data_sram_en) data_rdata_d = d_mmio ? mmio_rdata : mem_q[d_idx];
    if (mmio_wr && d_off == OFF_LED) begin
      if (bus.data_sram_wen[0]) led_d[7:0]  = bus.data_sram_wdata[7:0];
      if (bus.data_sram_wen[1]) led_d[15:8] = bus.data_sram_wdata[15:8];
    end
    if (mmio_wr && d_off == OFF_NUM)
      num_d = merge(num_q, bus.data_sram_wdata, bus.data_sram_wen);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      inst_rdata_q <= '0;
      data_rdata_q <= '0;
      led_q        <= '0;
      num_q        <= '0;
    end else begin
      inst_rdata_q <= inst_rdata_d;
      data_rdata_q <= data_rdata_d;
      led_q        <= led_d;
      num_q        <= num_d;
    end
  end

  // Array contents are deliberately not reset; only writes are gated.
  always_ff @(posedge clk) begin
    if (!rst && arr_wr) begin
      for (int i = 0; i < 4; i++)
        if (bus.data_sram_wen[i])
          mem_q[d_idx][8*i +: 8] <= bus.data_sram_wdata[8*i +: 8];
    end
  end

  assign bus.inst_sram_rdata = inst_rdata_q;
  assign bus.data_sram_rdata = data_rdata_q;
  assign led                 = led_q;
  assign num                 = num_q;

endmodule

// File: tb/tb_sram_responder.sv
// Bench for sram_responder: directed table, multi-cycle sequences (reset, timer)
// and random traffic against a word-level reference model.
module tb_sram_responder;
  localparam int AW = 12;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] led;
  logic [31:0] num;

  sram_responder_if bus();

  sram_responder #(.AW(AW), .MMIO_BASE(16'hBFAF)) dut (
    .clk(clk), .rst(rst), .bus(bus), .led(led), .num(num)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  // reference model state
  int unsigned cyc = 0;
  logic [31:0] m_mem [int unsigned];
  logic [31:0] e_i = '0, e_d = '0, m_num = '0, t_base = '0;
  logic [15:0] m_led = '0;
  int unsigned t_cyc = 0;

  typedef struct {
    logic        ie;
    logic [31:0] ia;
    logic        de;
    logic [3:0]  dw;
    logic [31:0] da;
    logic [31:0] dd;
    logic [3:0]  ck;   // which constants to check: {num, led, data, inst}
    logic [31:0] ei, ed, el, en;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t v(input logic ie, input logic [31:0] ia, input logic de,
                             input logic [3:0] dw, input logic [31:0] da, input logic [31:0] dd,
                             input logic [3:0] ck, input logic [31:0] ei, input logic [31:0] ed,
                             input logic [31:0] el, input logic [31:0] en);
    vec_t r;
    r.ie = ie; r.ia = ia; r.de = de; r.dw = dw; r.da = da; r.dd = dd;
    r.ck = ck; r.ei = ei; r.ed = ed; r.el = el; r.en = en;
    return r;
  endfunction

  function automatic logic [31:0] bmask(input logic [3:0] be);
    return {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
  endfunction

  function automatic logic [31:0] mrg(input logic [31:0] o, input logic [31:0] n,
                                      input logic [3:0] be);
    logic [31:0] m;
    m = bmask(be);
    return (o & ~m) | (n & m);
  endfunction

  function automatic int unsigned widx(input logic [31:0] a);
    logic [31:0] k;
    k = (a >> 2) & ((32'd1 << AW) - 32'd1);
    return k;
  endfunction

  function automatic logic [31:0] mrd(input logic [31:0] a);
    int unsigned k;
    k = widx(a);
    return m_mem.exists(k) ? m_mem[k] : 32'h0;
  endfunction

  // Timer as "value at base cycle plus elapsed cycles".
  function automatic logic [31:0] tval();
    logic [31:0] el;
    el = cyc - t_cyc;
    return t_base + el;
  endfunction

  function automatic logic [31:0] mmio_rd(input logic [15:0] off);
    case (off)
`ifdef SRAM_TIMER_EN
      16'hE000: return tval();
`endif
      16'hF000: return {16'h0000, m_led};
      16'hF010: return m_num;
      default:  return 32'h0;
    endcase
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic chk_model(input string nm);
    chk({nm, ".inst_rdata"}, bus.inst_sram_rdata, e_i);
    chk({nm, ".data_rdata"}, bus.data_sram_rdata, e_d);
    chk({nm, ".led"}, {16'h0, led}, {16'h0, m_led});
    chk({nm, ".num"}, num, m_num);
  endtask

  // Drive one cycle, advance the model, clock, and leave time at posedge+1.
  task automatic step(input logic r, input logic ie, input logic [31:0] ia, input logic de,
                      input logic [3:0] dw, input logic [31:0] da, input logic [31:0] dd);
    logic [15:0] off;
    logic [31:0] lm;
    rst = r;
    bus.inst_sram_en = ie; bus.inst_sram_addr = ia;
    bus.inst_sram_wen = 4'($urandom); bus.inst_sram_wdata = $urandom;
    bus.data_sram_en = de; bus.data_sram_wen = dw;
    bus.data_sram_addr = da; bus.data_sram_wdata = dd;
    if (r) begin
      e_i = '0; e_d = '0; m_led = '0; m_num = '0; t_base = '0; t_cyc = cyc + 1;
    end else begin
      if (ie) e_i = mrd(ia);
      if (de && da[31:16] == 16'hBFAF) begin
        off = {da[15:2], 2'b00};
        e_d = mmio_rd(off);
        if (dw != 4'b0) begin
          lm = bmask(dw);
          if (off == 16'hF000) m_led = (m_led & ~lm[15:0]) | (dd[15:0] & lm[15:0]);
          if (off == 16'hF010) m_num = mrg(m_num, dd, dw);
`ifdef SRAM_TIMER_EN
          if (off == 16'hE000) begin t_base = mrg(tval(), dd, dw); t_cyc = cyc + 1; end
`endif
        end
      end else if (de) begin
        e_d = mrd(da);
        if (dw != 4'b0) m_mem[widx(da)] = mrg(mrd(da), dd, dw);
      end
    end
    @(posedge clk);
    cyc++;
    #1;
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 32'h0, 1'b0, 4'h0, 32'h0, 32'h0);
  endtask

  initial begin
    logic [31:0] ia, da, dd, tv;
    logic [3:0]  dw;
    logic [15:0] offs [4];
    offs[0] = 16'hE000; offs[1] = 16'hF000; offs[2] = 16'hF010; offs[3] = 16'hF020;

    bus.inst_sram_en = 1'b0; bus.inst_sram_wen = '0; bus.inst_sram_addr = '0;
    bus.inst_sram_wdata = '0; bus.data_sram_en = 1'b0; bus.data_sram_wen = '0;
    bus.data_sram_addr = '0; bus.data_sram_wdata = '0;

    // reset state
    step(1'b1, 1'b0, 32'h0, 1'b0, 4'h0, 32'h0, 32'h0);
    step(1'b1, 1'b0, 32'h0, 1'b0, 4'h0, 32'h0, 32'h0);
    chk("reset.inst_rdata", bus.inst_sram_rdata, 32'h0);
    chk("reset.data_rdata", bus.data_sram_rdata, 32'h0);
    chk("reset.led", {16'h0, led}, 32'h0);
    chk("reset.num", num, 32'h0);

    tbl.push_back(v(0, 0, 1, 4'hF, 32'h10, 32'h11223344, 4'b0000, 0, 0, 0, 0));
    tbl.push_back(v(1, 32'h10, 1, 4'h0, 32'h10, 0, 4'b0011, 32'h11223344, 32'h11223344, 0, 0));
    tbl.push_back(v(0, 0, 1, 4'b0010, 32'h10, 32'hAABBCCDD, 4'b0000, 0, 0, 0, 0));
    tbl.push_back(v(0, 0, 1, 4'h0, 32'h10, 0, 4'b0010, 0, 32'h1122CC44, 0, 0));
    tbl.push_back(v(0, 0, 1, 4'b1000, 32'h10, 32'hAABBCCDD, 4'b0000, 0, 0, 0, 0));
    tbl.push_back(v(1, 32'h10, 1, 4'h0, 32'h10, 0, 4'b0011, 32'hAA22CC44, 32'hAA22CC44, 0, 0));
    tbl.push_back(v(0, 0, 1, 4'hF, 32'h10, 32'h0, 4'b0000, 0, 0, 0, 0));
    tbl.push_back(v(1, 32'h10, 1, 4'hF, 32'h10, 32'hDEADBEEF, 4'b0011, 32'h0, 32'h0, 0, 0));
    tbl.push_back(v(1, 32'h10, 0, 4'h0, 32'h0, 0, 4'b0001, 32'hDEADBEEF, 0, 0, 0));
    tbl.push_back(v(0, 0, 1, 4'hF, 32'hBFAF_F000, 32'h000000FF, 4'b0100, 0, 0, 32'hFF, 0));
    tbl.push_back(v(0, 0, 1, 4'hF, 32'hBFAF_F010, 32'h12345678, 4'b1000, 0, 0, 0, 32'h12345678));
    tbl.push_back(v(0, 0, 1, 4'h0, 32'hBFAF_F020, 0, 4'b0010, 0, 32'h0, 0, 0));
    tbl.push_back(v(1, 32'h0000_4010, 1, 4'h0, 32'hBFAF_F003, 0, 4'b0011, 32'hDEADBEEF, 32'hFF, 0, 0));
    tbl.push_back(v(0, 0, 0, 4'h0, 32'h0, 0, 4'b0011, 32'hDEADBEEF, 32'hFF, 0, 0));
    tbl.push_back(v(0, 0, 1, 4'b1100, 32'hBFAF_F000, 32'hFFFF0000, 4'b0100, 0, 0, 32'hFF, 0));
    tbl.push_back(v(0, 0, 1, 4'b0011, 32'hBFAF_F000, 32'hABCD1234, 4'b0100, 0, 0, 32'h1234, 0));
    tbl.push_back(v(0, 0, 1, 4'b0001, 32'hBFAF_F010, 32'h000000AA, 4'b1000, 0, 0, 0, 32'h123456AA));

    foreach (tbl[k]) begin
      step(1'b0, tbl[k].ie, tbl[k].ia, tbl[k].de, tbl[k].dw, tbl[k].da, tbl[k].dd);
      chk_model($sformatf("vec%0d.model", k));
      if (tbl[k].ck[0]) chk($sformatf("vec%0d.inst_rdata", k), bus.inst_sram_rdata, tbl[k].ei);
      if (tbl[k].ck[1]) chk($sformatf("vec%0d.data_rdata", k), bus.data_sram_rdata, tbl[k].ed);
      if (tbl[k].ck[2]) chk($sformatf("vec%0d.led", k), {16'h0, led}, tbl[k].el);
      if (tbl[k].ck[3]) chk($sformatf("vec%0d.num", k), num, tbl[k].en);
    end

    // mid-stream reset with a pending write that must not land
    step(1'b0, 1'b0, 32'h0, 1'b1, 4'hF, 32'h40, 32'h00000001);
    step(1'b0, 1'b0, 32'h0, 1'b1, 4'hF, 32'hBFAF_F000, 32'h000000FF);
    chk("rstseq.led_before", {16'h0, led}, 32'hFF);
    step(1'b1, 1'b1, 32'h40, 1'b1, 4'hF, 32'h40, 32'h00005555);
    step(1'b1, 1'b1, 32'h40, 1'b1, 4'hF, 32'h40, 32'h00005555);
    chk("rstseq.led", {16'h0, led}, 32'h0);
    chk("rstseq.inst_rdata", bus.inst_sram_rdata, 32'h0);
    chk("rstseq.data_rdata", bus.data_sram_rdata, 32'h0);
    step(1'b0, 1'b1, 32'h40, 1'b1, 4'h0, 32'h40, 32'h0);   // cycle 0 after reset
    chk("rstseq.inst_after", bus.inst_sram_rdata, 32'h1);
    chk("rstseq.data_after", bus.data_sram_rdata, 32'h1);
    chk_model("rstseq.model");

    // timer: read at cycle 10 after reset, then wrap through 0xFFFFFFFF
    for (int k = 1; k < 10; k++) idle();
    step(1'b0, 1'b0, 32'h0, 1'b1, 4'h0, 32'hBFAF_E000, 32'h0);
`ifdef SRAM_TIMER_EN
    tv = 32'd10;
`else
    tv = 32'd0;
`endif
    chk("timer.cycle10", bus.data_sram_rdata, tv);
    chk_model("timer.cycle10.model");
    step(1'b0, 1'b0, 32'h0, 1'b1, 4'hF, 32'hBFAF_E000, 32'hFFFFFFFE);
    idle();
    step(1'b0, 1'b0, 32'h0, 1'b1, 4'h0, 32'hBFAF_E000, 32'h0);
`ifdef SRAM_TIMER_EN
    tv = 32'hFFFFFFFF;
`else
    tv = 32'd0;
`endif
    chk("timer.max", bus.data_sram_rdata, tv);
    step(1'b0, 1'b0, 32'h0, 1'b1, 4'h0, 32'hBFAF_E000, 32'h0);
    chk("timer.wrap", bus.data_sram_rdata, 32'h0);
    chk_model("timer.wrap.model");

    // random traffic over a 32-word window plus the MMIO registers
    for (int k = 0; k < 32; k++) step(1'b0, 1'b0, 32'h0, 1'b1, 4'hF, 32'(k * 4), $urandom);
    for (int k = 0; k < 600; k++) begin
      ia = {$urandom_range(0, 32'h3FFFF), 5'($urandom), 2'($urandom)} & 32'h0003_FFFF;
      ia = (ia & ~32'h3FFC) | (32'($urandom_range(0, 31)) << 2);
      dw = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom);
      dd = $urandom;
      if ($urandom_range(0, 3) == 0) begin
        da = {16'hBFAF, ($urandom_range(0, 4) == 4) ? 16'($urandom) : offs[$urandom_range(0, 3)]};
        da[1:0] = 2'($urandom);
      end else begin
        da = $urandom;
        da[13:2] = 12'($urandom_range(0, 31));
        if (da[31:16] == 16'hBFAF) da[31:16] = 16'h0;
      end
      step($urandom_range(0, 49) == 0, 1'($urandom), ia, 1'($urandom), dw, da, dd);
      chk_model($sformatf("rand%0d", k));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/sram_responder.md
# sram_responder

Memory-side responder for the core's instruction and data SRAM-like ports. It backs both ports with one shared word array and answers every request with a fixed one-cycle read latency, because the core's pipeline has no wait handshake. It also decodes a small MMIO window on the data port: a free-running timer, an LED register and a numeric-display register. The block sits outside `mycpu_core` in the SoC top and ties directly to its `inst_sram_*` and `data_sram_*` pins.

## Interface
- `AW`, default 16: word-address width; the array is 2^AW words of 32 bits.
- `MMIO_BASE`, default 16'hBFAF: value of `data_sram_addr[31:16]` that selects the MMIO window instead of the array.
- `clk`  in  1  clock
- `rst`  in  1  reset; synchronous, active-high
- `inst_sram_en`  in  1  instruction read request
- `inst_sram_wen`  in  4  ignored; the instruction port is read-only
- `inst_sram_addr`  in  32  byte address; word index is `[AW+1:2]`
- `inst_sram_wdata`  in  32  ignored
- `inst_sram_rdata`  out  32  read data, valid the cycle after the request
- `data_sram_en`  in  1  data request
- `data_sram_wen`  in  4  byte write enables; bit i selects byte i; 0 means read
- `data_sram_addr`  in  32  byte address
- `data_sram_wdata`  in  32  write data
- `data_sram_rdata`  out  32  read data, valid the cycle after the request
- `led`  out  16  LED register
- `num`  out  32  numeric-display register

## Operation
**Instruction port**
- When `inst_sram_en=1` in cycle N, `inst_sram_rdata` equals `mem[inst_sram_addr[AW+1:2]]` from cycle N+1.
- When `en=0`, `rdata` holds its last value.
- Upper address bits are discarded, so addresses wrap modulo 2^(AW+2).

**Data port, array access** (`en=1` and `addr[31:16]!=MMIO_BASE`)
- Read (`wen=0`): same timing as the instruction port.
- Write (`wen!=0`): byte lane i of the word is replaced by `wdata[8i+7:8i]` when `wen[i]=1`. The update is visible from cycle N+1.
- `data_sram_rdata` in N+1 returns the pre-write word (read-first).

**Data port, MMIO access** (`en=1` and `addr[31:16]==MMIO_BASE`)
- Offsets are taken from `addr[15:0]`; low two bits are ignored.
- 0xE000 TIMER: 32 bits; read/write.
- 0xF000 LED: 16 bits; read returns zero-extended value; byte lanes 2–3 are ignored on write.
- 0xF010 NUM: 32 bits; read/write.
- Unmapped offsets read 0; writes to them are dropped.
- Writes obey byte enables exactly as array writes do.
- A read returns the register value as it stood in cycle N, before any same-cycle write or increment.
- No MMIO access reaches the array.

**Timer**
- Increments by 1 every cycle and wraps from 0xFFFFFFFF to 0.
- A write in cycle N sets TIMER to merge(old, wdata, wen) at the edge ending N; the increment is suppressed for that edge. Incrementing resumes from N+1.

**Simultaneous events**
- Instruction read and data write to the same word in the same cycle: the instruction port returns the old word.
- Requests on both ports are always accepted; there is no arbitration stall.

## Timing
- Read latency is exactly 1 cycle on both ports. Write takes effect at the edge ending the request cycle.
- Reset values: `inst_sram_rdata`=0, `data_sram_rdata`=0, `led`=0, `num`=0, TIMER=0.
- Array contents are not reset.
- `rst` asserted mid-stream: requests in reset cycles are ignored (no write, no rdata update). The first request in the cycle after `rst` deasserts is served normally.
- `led` and `num` are driven directly from their registers, so a write in N is visible on the pins in N+1.

## Configuration
- `SRAM_TIMER_EN` defined: TIMER is implemented as described above.
- `SRAM_TIMER_EN` undefined:
  - No timer register is synthesised.
  - Offset 0xE000 behaves as unmapped: reads 0, writes are dropped.
  - All other behaviour is unchanged.

## Test plan
- Data write 0x11223344 to 0x0000_0010 (`wen`=1111), then read it back on both ports → both `rdata` equal 0x11223344 one cycle after each request.
- Partial writes:
  - `wen`=0010 with wdata 0xAABBCCDD on word 0x11223344 → readback 0x1122CC44.
  - `wen`=1000 with the same wdata, applied next → readback 0xAA22CC44.
- Same cycle: instruction read and data write of 0xDEADBEEF to word 4 (previously 0) → `inst_sram_rdata`=0 in N+1; an instruction read in N+1 returns 0xDEADBEEF in N+2.
- MMIO:
  - Write 0x0000_00FF to 0xBFAF_F000 → `led`=0x00FF next cycle.
  - Write 0x12345678 to 0xBFAF_F010 → `num`=0x12345678.
  - Read 0xBFAF_F020 → `data_sram_rdata`=0.
- Timer (with `SRAM_TIMER_EN`):
  - After reset, read TIMER at cycle 10 → returns 10.
  - Write 0xFFFFFFFE, then read two cycles later → returns 0xFFFFFFFF; the following cycle's read returns 0.
  - Without the macro, reading TIMER returns 0.
- Reset mid-operation: assert `rst` for 2 cycles while `led`=0x00FF and a write request is pending → `led`=0, both `rdata`=0, and the pending write does not reach the array.
